iwdg_ctrl: RTL

Wishbone master sequencer that configures, starts and refreshes the IWDG slave on behalf of software and system logic. It issues the key/prescale/reload write sequence, arms the watchdog, then services refresh requests from a heartbeat pulse and an optional internal auto-refresh timer. It reports progress, arming state and bus faults. It sits between the system control logic and the IWDG Wishbone slave port, in the clk_m2s domain.

---
 rtl/iwdg_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/iwdg_ctrl.sv
// Wishbone write-only master that unlocks, configures, starts and refreshes an IWDG slave.
// Debug view of the sequencer: dbg_state carries the state_e encoding (IDLE=0 .. FAULT=7).
module iwdg_ctrl #(
    parameter int          GRL              = 1,
    parameter logic [31:0] BASE_ADR         = 32'h0100_0000,
    parameter int          ACK_TIMEOUT      = 16,
    parameter int          AUTO_KICK_PERIOD = 0,
    parameter int          CNT_W            = 24
) (
    input  logic         clk_m2s,
    input  logic         rst_m2s,
    input  logic         cfg_start,
    input  logic [2:0]   cfg_pr,
    input  logic [11:0]  cfg_rlr,
    input  logic         kick,
    input  logic         clr_fault,
    output logic [31:0]  adr_m2s,
    output logic [31:0]  dat_m2s,
    output logic [GRL:0] sel_m2s,
    output logic         cyc_m2s,
    output logic         stb_m2s,
    output logic         we_m2s,
    input  logic [31:0]  dat_s2m,
    input  logic         ack_s2m,
    input  logic         err_s2m,
    output logic         busy,
    output logic         armed,
    output logic         fault,
    output logic [15:0]  kick_cnt,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNLOCK = 3'd1,
        S_WR_PR  = 3'd2,
        S_WR_RLR = 3'd3,
        S_START  = 3'd4,
        S_ARMED  = 3'd5,
        S_KICK   = 3'd6,
        S_FAULT  = 3'd7
    } state_e;

    localparam int              TO_W       = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(ACK_TIMEOUT - 1);
    localparam int              AKP_LAST_I = (AUTO_KICK_PERIOD > 0) ? AUTO_KICK_PERIOD - 1 : 0;
    localparam logic [CNT_W-1:0] AKP_LAST  = CNT_W'(AKP_LAST_I);

    localparam logic [31:0] KEY_UNLOCK = 32'h0000_5555;
    localparam logic [31:0] KEY_START  = 32'h0000_CCCC;
    localparam logic [31:0] KEY_REFR   = 32'h0000_AAAA;

    state_e           state_q, state_d;
    logic             cyc_q, cyc_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic [GRL:0]     sel_q, sel_d;
    logic             armed_q, armed_d;
    logic             fault_q, fault_d;
    logic             pend_q, pend_d;
    logic [15:0]      kcnt_q, kcnt_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [CNT_W-1:0] auto_q, auto_d;
    logic [2:0]       pr_q, pr_d;
    logic [11:0]      rlr_q, rlr_d;

    logic [31:0] wr_adr;
    logic [31:0] wr_dat;
    logic        unused_dat;

    assign unused_dat = ^dat_s2m;

    always_ff @(posedge clk_m2s) begin
        if (!rst_m2s) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            armed_q <= 1'b0;
            fault_q <= 1'b0;
            pend_q  <= 1'b0;
            kcnt_q  <= '0;
            to_q    <= '0;
            auto_q  <= '0;
            pr_q    <= '0;
            rlr_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            armed_q <= armed_d;
            fault_q <= fault_d;
            pend_q  <= pend_d;
            kcnt_q  <= kcnt_d;
            to_q    <= to_d;
            auto_q  <= auto_d;
            pr_q    <= pr_d;
            rlr_q   <= rlr_d;
        end
    end

    // Address/data presented by each write state; START re-uses the refresh key when already running.
    always_comb begin
        wr_adr = '0;
        wr_dat = '0;
        case (state_q)
            S_UNLOCK: begin wr_adr = BASE_ADR;            wr_dat = KEY_UNLOCK;      end
            S_WR_PR:  begin wr_adr = BASE_ADR + 32'h4;    wr_dat = {29'b0, pr_q};   end
            S_WR_RLR: begin wr_adr = BASE_ADR + 32'h8;    wr_dat = {20'b0, rlr_q};  end
            S_START:  begin wr_adr = BASE_ADR;            wr_dat = armed_q ? KEY_REFR : KEY_START; end
            S_KICK:   begin wr_adr = BASE_ADR;            wr_dat = KEY_REFR;        end
            default:  begin wr_adr = '0;                  wr_dat = '0;              end
        endcase
    end

    // Handshake: a write state spends one cycle with cyc=0 (launch), then holds cyc/stb/adr/dat
    // until ack or err is sampled; err (alone or with ack) or an expired timeout ends in FAULT.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        armed_d = armed_q;
        fault_d = fault_q;
        pend_d  = pend_q;
        kcnt_d  = kcnt_q;
        to_d    = to_q;
        auto_d  = auto_q;
        pr_d    = pr_q;
        rlr_d   = rlr_q;

        if (AUTO_KICK_PERIOD > 0 && armed_q) begin
            if (auto_q == AKP_LAST) begin
                auto_d = '0;
                pend_d = 1'b1;
            end else begin
                auto_d = auto_q + CNT_W'(1);
            end
        end else begin
            auto_d = '0;
        end

        if (kick && armed_q && state_q != S_IDLE && state_q != S_FAULT) begin
            pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    state_d = S_UNLOCK;
                    pr_d    = cfg_pr;
                    rlr_d   = cfg_rlr;
                end
            end
            S_ARMED: begin
                if (cfg_start) begin
                    state_d = S_UNLOCK;
                    pr_d    = cfg_pr;
                    rlr_d   = cfg_rlr;
                end else if (pend_q) begin
                    state_d = S_KICK;
                    pend_d  = 1'b0;
                end
            end
            S_FAULT: begin
                if (clr_fault) begin
                    state_d = S_IDLE;
                    fault_d = 1'b0;
                end
            end
            default: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    adr_d = wr_adr;
                    dat_d = wr_dat;
                    sel_d = '1;
                    to_d  = '0;
                end else if (err_s2m || (!ack_s2m && to_q == TO_LAST)) begin
                    cyc_d   = 1'b0;
                    adr_d   = '0;
                    dat_d   = '0;
                    sel_d   = '0;
                    state_d = S_FAULT;
                    armed_d = 1'b0;
                    fault_d = 1'b1;
                    pend_d  = 1'b0;
                    auto_d  = '0;
                end else if (ack_s2m) begin
                    cyc_d = 1'b0;
                    adr_d = '0;
                    dat_d = '0;
                    sel_d = '0;
                    case (state_q)
                        S_UNLOCK: state_d = S_WR_PR;
                        S_WR_PR:  state_d = S_WR_RLR;
                        S_WR_RLR: state_d = S_START;
                        S_START: begin
                            state_d = S_ARMED;
                            armed_d = 1'b1;
                        end
                        S_KICK: begin
                            state_d = S_ARMED;
                            auto_d  = '0;
                            if (kcnt_q != 16'hFFFF) kcnt_d = kcnt_q + 16'd1;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
        endcase
    end

    assign adr_m2s   = adr_q;
    assign dat_m2s   = dat_q;
    assign sel_m2s   = sel_q;
    assign cyc_m2s   = cyc_q;
    assign stb_m2s   = cyc_q;
    assign we_m2s    = cyc_q;
    assign busy      = (state_q == S_UNLOCK) || (state_q == S_WR_PR) || (state_q == S_WR_RLR) ||
                       (state_q == S_START)  || (state_q == S_KICK);
    assign armed     = armed_q;
    assign fault     = fault_q;
    assign kick_cnt  = kcnt_q;
    assign dbg_state = state_q;

endmodule
